alu_ext: RTL

Parametrised, handshaked ALU for the RISC CPU core. It replaces the fixed 8-bit, 8-opcode ALU with one of width `W`, a 4-bit opcode space, registered status flags (zero, carry, negative, overflow) and an optional multi-cycle shift-add multiplier. It sits between the accumulator/operand path and the controller. The controller issues operations with a valid/ready handshake and samples `result` on `out_valid`.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_mul_seq.sv | 55 +++++
 rtl/alu_ext.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, status flag bundle, default width.
// Used by alu_ext, alu_mul_seq and the controller decoder.
package alu_pkg;

    localparam int unsigned AluDefaultWidth = 8;

    typedef enum logic [3:0] {
        OpHlt = 4'h0,
        OpSkz = 4'h1,
        OpAdd = 4'h2,
        OpAnd = 4'h3,
        OpXor = 4'h4,
        OpLda = 4'h5,
        OpSto = 4'h6,
        OpJmp = 4'h7,
        OpSub = 4'h8,
        OpOr  = 4'h9,
        OpShl = 4'hA,
        OpShr = 4'hB,
        OpAsr = 4'hC,
        OpMul = 4'hD,
        OpAdc = 4'hE,
        OpRsv = 4'hF
    } alu_op_e;

    typedef struct packed {
        logic z;
        logic c;
        logic n;
        logic v;
    } alu_flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier, one multiplier bit per step.
// start loads the operands; each step folds in one bit; done is asserted
// combinationally during the final step, with product carrying that step's sum.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int unsigned W = AluDefaultWidth
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         step,
    input  logic         kill,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic [W-1:0] product
);
    localparam int unsigned CW = $clog2(W);

    logic [CW-1:0] cnt_q;
    logic [W-1:0]  acc_q;
    logic [W-1:0]  mcand_q;
    logic [W-1:0]  mplier_q;
    logic [W-1:0]  acc_nxt;

    assign acc_nxt = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign done    = step && !kill && (cnt_q == CW'(W - 1));
    assign product = acc_nxt;

    // Operand load on start, one shift-add iteration per step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (start) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= a;
            mplier_q <= b;
        end else if (step) begin
            if (kill || done) begin
                cnt_q <= '0;
            end else begin
                cnt_q    <= cnt_q + 1'b1;
                acc_q    <= acc_nxt;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
            end
        end
    end

endmodule

// File: rtl/alu_ext.sv
// Handshaked W-bit ALU with registered result and status flags.
// Optional multi-cycle multiplier (op D) compiled in when ALU_MUL_EN is defined;
// otherwise op D is treated as a reserved opcode.
module alu_ext
    import alu_pkg::*;
#(
    parameter int unsigned W = AluDefaultWidth
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   op,
    input  logic [W-1:0] accum,
    input  logic [W-1:0] data,
    input  logic         kill,
    output logic         acc_zero,
    output logic [W-1:0] result,
    output logic         out_valid,
    output logic         flag_z,
    output logic         flag_c,
    output logic         flag_n,
    output logic         flag_v,
    output logic         illegal
);
    localparam int unsigned LW = $clog2(W);

    alu_op_e    op_e;
    logic       accept;
    logic       mul_issue;
    logic       mul_done;
    logic [W-1:0] mul_product;

    logic [W-1:0] result_q, result_d;
    alu_flags_t   flags_q, flags_d;
    logic         out_valid_q, out_valid_d;
    logic         illegal_q, illegal_d;

    logic [W-1:0]  sc_res;
    alu_flags_t    sc_flags;
    logic          sc_illegal;
    logic [LW-1:0] shamt;
    logic [W:0]    sum;
    logic [W:0]    diff;
    logic [W:0]    shl_ext;
    logic [W:0]    shr_ext;
    logic [W:0]    asr_ext;

    assign acc_zero = (accum == '0);
    assign op_e     = alu_op_e'(op);
    assign shamt    = data[LW-1:0];
    assign accept   = in_valid && in_ready && !kill;

    // Single-cycle datapath; the extra bit of each *_ext holds the carry/last bit out.
    always_comb begin
        sum     = {1'b0, accum} + {1'b0, data} +
                  ((op_e == OpAdc) ? {{W{1'b0}}, flags_q.c} : '0);
        diff    = {1'b0, accum} - {1'b0, data};
        shl_ext = {1'b0, accum} << shamt;
        shr_ext = {accum, 1'b0} >> shamt;
        asr_ext = $unsigned($signed({accum, 1'b0}) >>> shamt);

        sc_res     = accum;
        sc_flags   = flags_q;
        sc_flags.v = 1'b0;
        sc_illegal = 1'b0;
        case (op_e)
            OpAdd, OpAdc: begin
                sc_res     = sum[W-1:0];
                sc_flags.c = sum[W];
                sc_flags.v = (accum[W-1] == data[W-1]) && (sum[W-1] != accum[W-1]);
            end
            OpSub: begin
                sc_res     = diff[W-1:0];
                sc_flags.c = diff[W];
                sc_flags.v = (accum[W-1] != data[W-1]) && (diff[W-1] != accum[W-1]);
            end
            OpAnd: sc_res = accum & data;
            OpXor: sc_res = accum ^ data;
            OpOr:  sc_res = accum | data;
            OpLda: sc_res = data;
            OpShl: begin
                sc_res = shl_ext[W-1:0];
                if (shamt != '0) sc_flags.c = shl_ext[W];
            end
            OpShr: begin
                sc_res = shr_ext[W:1];
                if (shamt != '0) sc_flags.c = shr_ext[0];
            end
            OpAsr: begin
                sc_res = asr_ext[W:1];
                if (shamt != '0) sc_flags.c = asr_ext[0];
            end
`ifndef ALU_MUL_EN
            OpMul: sc_illegal = 1'b1;
`endif
            OpRsv: sc_illegal = 1'b1;
            default: sc_res = accum;
        endcase

        if (sc_illegal) begin
            sc_flags = flags_q;
        end else begin
            sc_flags.z = (sc_res == '0);
            sc_flags.n = sc_res[W-1];
        end
    end

`ifdef ALU_MUL_EN
    typedef enum logic [0:0] {StIdle, StMul} state_e;
    state_e state_q, state_d;

    assign mul_issue = (op_e == OpMul);

    alu_mul_seq #(
        .W(W)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && mul_issue),
        .step    (state_q == StMul),
        .kill    (kill),
        .a       (accum),
        .b       (data),
        .done    (mul_done),
        .product (mul_product)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Next-state and handshake: busy for the whole multiply, kill aborts it.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (accept && mul_issue) state_d = StMul;
            end
            StMul: begin
                if (kill || mul_done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end
`else
    assign mul_issue   = 1'b0;
    assign mul_done    = 1'b0;
    assign mul_product = '0;
    assign in_ready    = 1'b1;
`endif

    // Completion selection: single-cycle accept or multiplier finish (never both).
    always_comb begin
        result_d    = result_q;
        flags_d     = flags_q;
        out_valid_d = 1'b0;
        illegal_d   = 1'b0;
        if (accept && !mul_issue) begin
            result_d    = sc_res;
            flags_d     = sc_flags;
            out_valid_d = 1'b1;
            illegal_d   = sc_illegal;
        end else if (mul_done) begin
            result_d    = mul_product;
            flags_d.z   = (mul_product == '0);
            flags_d.n   = mul_product[W-1];
            flags_d.v   = 1'b0;
            out_valid_d = 1'b1;
        end
    end

    // Output and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            result_q    <= result_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
        end
    end

    assign result    = result_q;
    assign out_valid = out_valid_q;
    assign illegal   = illegal_q;
    assign flag_z    = flags_q.z;
    assign flag_c    = flags_q.c;
    assign flag_n    = flags_q.n;
    assign flag_v    = flags_q.v;

endmodule
